// File: rtl/sram_chk_pkg.sv
// Shared constants, strobe-merge helper and first-error record for the SRAM shadow checker.
// Widths in this package are upper bounds; instances slice down to their own DW/AW.
package sram_chk_pkg;

   localparam int DEF_DW     = 32;
   localparam int DEF_AW     = 8;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_CW     = 16;

   localparam int MAX_DW = 256;
   localparam int MAX_AW = 32;
   localparam int MAX_SW = MAX_DW / 8;

   typedef struct packed {
      logic [MAX_AW-1:0] adr;
      logic [MAX_DW-1:0] exp;
      logic [MAX_DW-1:0] act;
   } err_rec_t;

   function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_SW-1:0] strb);
      logic [MAX_DW-1:0] m;
      m = old_w;
      for (int b = 0; b < MAX_SW; b++) begin
         if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/sram_chk_dly.sv
// Valid+data delay line of LAT stages; only the valid bits are reset so that
// a reset drops in-flight entries while the data stages stay plain registers.
module sram_chk_dly #(
   parameter int W   = 8,
   parameter int LAT = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         vld_i,
   input  logic [W-1:0] dat_i,
   output logic         vld_o,
   output logic [W-1:0] dat_o
);

   logic [LAT-1:0] vld_q;
   logic [W-1:0]   dat_q [LAT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= vld_i;
         for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      dat_q[0] <= dat_i;
      for (int i = 1; i < LAT; i++) dat_q[i] <= dat_q[i-1];
   end

   assign vld_o = vld_q[LAT-1];
   assign dat_o = dat_q[LAT-1];

endmodule

// File: rtl/sram_shadow_chk.sv
// Shadow-memory scoreboard snooping a single-port SRAM; compares every read response.
// Optional per-word valid tracking (skip unwritten words) with `define SRAM_CHK_VLD_TRACK_EN.
module sram_shadow_chk
   import sram_chk_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int CW     = DEF_CW
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_cen,
   input  logic            io_wen,
   input  logic [DW/8-1:0] io_wstrb,
   input  logic [AW-1:0]   io_adr,
   input  logic [DW-1:0]   io_d,
   input  logic [DW-1:0]   io_q,
   input  logic            init_en,
   input  logic [AW-1:0]   init_adr,
   input  logic [DW-1:0]   init_d,
   output logic            err,
   output logic [CW-1:0]   err_cnt,
   output logic [AW-1:0]   err_adr,
   output logic [DW-1:0]   err_exp,
   output logic [DW-1:0]   err_act,
   output logic [CW-1:0]   wr_cnt,
   output logic [CW-1:0]   rd_cnt,
   output logic [CW-1:0]   skip_cnt
);

   localparam int DEPTH = 2 ** AW;
   localparam int PW    = 1 + AW + DW;

   logic            rd_req, wr_req, push_chk;
   logic [DW-1:0]   rd_word, wr_word;
   logic            dly_vld;
   logic [PW-1:0]   dly_dat;
   logic            exp_chk, do_cmp, mismatch;
   logic [AW-1:0]   exp_adr;
   logic [DW-1:0]   exp_word;

   logic            err_q, err_d;
   logic [CW-1:0]   err_cnt_q, err_cnt_d;
   logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
   err_rec_t        rec_q, rec_d;

   logic [DW-1:0]   mem_q [DEPTH];

   assign rd_req  = !io_cen && io_wen;
   assign wr_req  = !io_cen && !io_wen;
   assign rd_word = mem_q[io_adr];
   assign wr_word = DW'(strb_merge(MAX_DW'(rd_word), MAX_DW'(io_d), MAX_SW'(io_wstrb)));

   // NOTE: the shadow array is deliberately not reset: contents must survive reset and it maps onto RAM.
   always_ff @(posedge clock) begin
      if (wr_req)  mem_q[io_adr]   <= wr_word;
      if (init_en) mem_q[init_adr] <= init_d;
   end

`ifdef SRAM_CHK_VLD_TRACK_EN
   logic [DEPTH-1:0] vld_q;
   logic [CW-1:0]    skip_cnt_q, skip_cnt_d;
   logic             do_skip;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         if (wr_req && (&io_wstrb)) vld_q[io_adr]   <= 1'b1;
         if (init_en)               vld_q[init_adr] <= 1'b1;
      end
   end

   assign push_chk = vld_q[io_adr];
   assign do_skip  = dly_vld && !exp_chk;

   always_comb begin
      skip_cnt_d = skip_cnt_q;
      if (do_skip && (skip_cnt_q != '1)) skip_cnt_d = skip_cnt_q + CW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) skip_cnt_q <= '0;
      else       skip_cnt_q <= skip_cnt_d;
   end

   assign skip_cnt = skip_cnt_q;
`else
   assign push_chk = 1'b1;
   assign skip_cnt = '0;
`endif

   sram_chk_dly #(.W(PW), .LAT(RD_LAT)) u_dly (
      .clock (clock),
      .reset (reset),
      .vld_i (rd_req),
      .dat_i ({push_chk, io_adr, rd_word}),
      .vld_o (dly_vld),
      .dat_o (dly_dat)
   );

   assign {exp_chk, exp_adr, exp_word} = dly_dat;
   assign do_cmp   = dly_vld && exp_chk;
   assign mismatch = do_cmp && (io_q != exp_word);

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      rec_d     = rec_q;
      if (wr_req && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CW'(1);
      if (do_cmp && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CW'(1);
      if (mismatch) begin
         err_d = 1'b1;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
         // Capture only the first mismatch since reset.
         if (err_cnt_q == '0) begin
            rec_d.adr = MAX_AW'(exp_adr);
            rec_d.exp = MAX_DW'(exp_word);
            rec_d.act = MAX_DW'(io_q);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         rec_q     <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         rec_q     <= rec_d;
      end
   end

   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign rd_cnt  = rd_cnt_q;
   assign err_adr = AW'(rec_q.adr);
   assign err_exp = DW'(rec_q.exp);
   assign err_act = DW'(rec_q.act);

endmodule
